// File: rtl/stream_master_if.sv
// AXI4-Stream bus bundle used by stream_master (master side) and its sink (slave side).
interface stream_master_if #(
  parameter int W = 32
);
  logic           tvalid;
  logic [W-1:0]   tdata;
  logic [W/8-1:0] tstrb;
  logic           tlast;
  logic           tready;

  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave  (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/stream_master.sv
// stream_master: AXI4-Stream egress. Buffers {valid,data} samples in a FIFO, drives the
// stream through a stall-safe output register, and tags every FRAME_LEN-th beat with TLAST.
// Optional feature macro: STREAM_MASTER_DROP_CNT_EN adds a saturating drop_cnt[15:0] output.
module stream_master #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int FRAME_LEN            = 64,
  parameter int AF_MARGIN            = 2
) (
  input  logic                          M_AXIS_ACLK,
  input  logic                          M_AXIS_ARESET,
  // {valid, data}: valid is the MSB
  input  logic [C_M_AXIS_TDATA_WIDTH:0] data_in,
  output logic                          is_ready,
  output logic                          overflow,
`ifdef STREAM_MASTER_DROP_CNT_EN
  output logic [15:0]                   drop_cnt,
`endif
  stream_master_if.master               m_axis
);
  localparam int W  = C_M_AXIS_TDATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic [FW-1:0] frame_cnt;
  logic          tvalid_q, tlast_q;
  logic [W-1:0]  tdata_q;

  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          full, push, drop, load, frame_last;

  assign in_valid   = data_in[W];
  assign in_data    = data_in[W-1:0];
  // Full is judged on the registered count only; a same-cycle pop never frees a slot for a write.
  assign full       = (count == CW'(FIFO_DEPTH));
  assign push       = in_valid && !full;
  assign drop       = in_valid && full;
  // The output register takes the FIFO head whenever it is empty or being consumed.
  assign load       = (count != '0) && (!tvalid_q || m_axis.tready);
  assign frame_last = (frame_cnt == FW'(FRAME_LEN - 1));

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tstrb  = '1;

  // Next FIFO occupancy; push and pop together leave it unchanged.
  always_comb begin
    count_nxt = count;
    if (push && !load)
      count_nxt = count + CW'(1);
    else if (!push && load)
      count_nxt = count - CW'(1);
  end

  // FIFO storage; contents need no reset since pointers/count define validity.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  // FIFO pointers, occupancy, upstream ready and sticky overflow.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      is_ready <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      is_ready <= (FIFO_DEPTH - int'(count_nxt)) >= AF_MARGIN;
      if (drop) overflow <= 1'b1;
    end
  end

  // Output beat register and frame position; holds steady while stalled.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      frame_cnt <= '0;
    end else if (load) begin
      tvalid_q  <= 1'b1;
      tdata_q   <= mem[rd_ptr];
      tlast_q   <= frame_last;
      frame_cnt <= frame_last ? '0 : frame_cnt + FW'(1);
    end else if (m_axis.tready) begin
      tvalid_q  <= 1'b0;
    end
  end

`ifdef STREAM_MASTER_DROP_CNT_EN
  // Saturating count of samples rejected because the FIFO was full.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET)
      drop_cnt <= '0;
    else if (drop && drop_cnt != 16'hFFFF)
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule
